// File: rtl/hazard_scheduler_pkg.sv
// Shared constants and types for the pipeline hazard scheduler.
package hazard_scheduler_pkg;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_DRAIN    = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    localparam int WAIT_W  = 8;
    localparam int DRAIN_W = 2;
    localparam logic [DRAIN_W-1:0] DRAIN_DEPTH = 2'd3;

    // Enable bundle order: {pc, if_id, id_ex, ex_mem, mem_wb}
    localparam int STAGE_EN_W = 5;
    localparam logic [STAGE_EN_W-1:0] EN_ALL  = 5'b11111;
    localparam logic [STAGE_EN_W-1:0] EN_NONE = 5'b00000;
    localparam logic [STAGE_EN_W-1:0] EN_BACK = 5'b00111;

endpackage

// File: rtl/hazard_scheduler_detect.sv
// Load-use comparator: a load in EX whose destination feeds an ID source.
module hazard_detect (
    input  logic       mem_read_EX,
    input  logic [4:0] reg_dest_EX,
    input  logic [4:0] reg_rs_ID,
    input  logic [4:0] reg_rt_ID,
    output logic       load_use
);

    assign load_use = mem_read_EX && (reg_dest_EX != 5'd0) &&
                      ((reg_dest_EX == reg_rs_ID) || (reg_dest_EX == reg_rt_ID));

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: stage enables/flushes for memory stalls,
// branches, halts and load-use hazards.
//
// state      | meaning
// S_RUN      | normal issue, hazards resolved by priority
// S_MEM_WAIT | memory access outstanding, pipeline frozen
// S_DRAIN    | front end held, back end emptying after a halt
// S_HALTED   | everything stopped until reset
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter logic [7:0] MEM_TIMEOUT = 8'd255,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read_EX,
    input  logic [4:0]       reg_dest_EX,
    input  logic [4:0]       reg_rs_ID,
    input  logic [4:0]       reg_rt_ID,
    input  logic             branch_taken_EX,
    input  logic             halt_ID,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t                  state;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [WAIT_W-1:0]       wait_inc;
    logic [DRAIN_W-1:0]      drain_cnt;
    logic                    ret_drain;
    logic                    load_use;
    logic                    mem_stall;
    logic [STAGE_EN_W-1:0]   en;
    logic                    if_flush_c;
    logic                    id_flush_c;

    hazard_detect u_detect (
        .mem_read_EX (mem_read_EX),
        .reg_dest_EX (reg_dest_EX),
        .reg_rs_ID   (reg_rs_ID),
        .reg_rt_ID   (reg_rt_ID),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req_MEM && !mem_ready;
    assign wait_inc  = (wait_cnt == '1) ? wait_cnt : wait_cnt + 8'd1;

    always_comb begin
        en         = EN_NONE;
        if_flush_c = 1'b0;
        id_flush_c = 1'b0;
        unique case (state)
            S_RUN: begin
                if (mem_stall) begin
                    en = EN_NONE;
                end else if (branch_taken_EX) begin
                    en         = EN_ALL;
                    if_flush_c = 1'b1;
                    id_flush_c = 1'b1;
                end else if (halt_ID || load_use) begin
                    en         = EN_BACK;
                    id_flush_c = 1'b1;
                end else begin
                    en = EN_ALL;
                end
            end
            S_MEM_WAIT: en = mem_ready ? EN_ALL : EN_NONE;
            S_DRAIN: begin
                if (!mem_stall) begin
                    en         = EN_BACK;
                    id_flush_c = 1'b1;
                end
            end
            S_HALTED: en = EN_NONE;
            default:  en = EN_NONE;
        endcase
        if (rst) begin
            en         = EN_NONE;
            if_flush_c = 1'b0;
            id_flush_c = 1'b0;
        end
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
    assign if_id_flush = if_flush_c;
    assign id_ex_flush = id_flush_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            wait_cnt     <= '0;
            drain_cnt    <= '0;
            ret_drain    <= 1'b0;
            stall_cycles <= '0;
            mem_timeout  <= 1'b0;
            halted       <= 1'b0;
        end else begin
            if (!pc_en && state != S_HALTED && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);

            unique case (state)
                S_RUN: begin
                    if (mem_stall) begin
                        state     <= S_MEM_WAIT;
                        wait_cnt  <= '0;
                        ret_drain <= 1'b0;
                        if (MEM_TIMEOUT == 8'd0) mem_timeout <= 1'b1;
                    end else if (!branch_taken_EX && halt_ID) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_DEPTH;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ready) begin
                        // The release cycle advances the back end, so it counts as drain progress.
                        if (ret_drain) begin
                            state     <= S_DRAIN;
                            drain_cnt <= (drain_cnt != '0) ? drain_cnt - 2'd1 : '0;
                        end else begin
                            state <= S_RUN;
                        end
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == MEM_TIMEOUT) mem_timeout <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (mem_stall) begin
                        state     <= S_MEM_WAIT;
                        wait_cnt  <= '0;
                        ret_drain <= 1'b1;
                        if (MEM_TIMEOUT == 8'd0) mem_timeout <= 1'b1;
                    end else if (drain_cnt <= 2'd1) begin
                        state     <= S_HALTED;
                        drain_cnt <= '0;
                        halted    <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed and randomized checks of hazard_scheduler against a behavioural model.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read_EX = 1'b0;
    logic [4:0]  reg_dest_EX = '0;
    logic [4:0]  reg_rs_ID = '0;
    logic [4:0]  reg_rt_ID = '0;
    logic        branch_taken_EX = 1'b0;
    logic        halt_ID = 1'b0;
    logic        mem_req_MEM = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, halted, mem_timeout;
    logic [15:0] stall_cycles;

    hazard_scheduler #(.MEM_TIMEOUT(8'd3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_read_EX(mem_read_EX), .reg_dest_EX(reg_dest_EX),
        .reg_rs_ID(reg_rs_ID), .reg_rt_ID(reg_rt_ID),
        .branch_taken_EX(branch_taken_EX), .halt_ID(halt_ID),
        .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halted(halted), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: pipeline mode plus plain integer counters.
    localparam int M_RUN = 0, M_WAIT = 1, M_DRAIN = 2, M_STOP = 3;
    localparam int T_MEM = 3;
    // Actions as {if_id_flush, id_ex_flush, pc, if_id, id_ex, ex_mem, mem_wb}
    localparam logic [6:0] A_GO     = 7'b00_11111;
    localparam logic [6:0] A_FREEZE = 7'b00_00000;
    localparam logic [6:0] A_SQUASH = 7'b11_11111;
    localparam logic [6:0] A_BUBBLE = 7'b01_00111;

    int m_mode, m_waited, m_drain_left, m_stalls;
    bit m_back_to_drain, m_timeout;

    function automatic logic [6:0] model_action();
        bit stall = mem_req_MEM && !mem_ready;
        bit lu = mem_read_EX && (reg_dest_EX != 0) &&
                 (reg_dest_EX == reg_rs_ID || reg_dest_EX == reg_rt_ID);
        case (m_mode)
            M_RUN:   return stall ? A_FREEZE : branch_taken_EX ? A_SQUASH :
                            (halt_ID || lu) ? A_BUBBLE : A_GO;
            M_WAIT:  return mem_ready ? A_GO : A_FREEZE;
            M_DRAIN: return stall ? A_FREEZE : A_BUBBLE;
            default: return A_FREEZE;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_waited = 0; m_drain_left = 0; m_stalls = 0;
        m_back_to_drain = 0; m_timeout = 0;
    endtask

    task automatic model_step(input logic [6:0] act);
        bit stall = mem_req_MEM && !mem_ready;
        if (act[4] == 1'b0 && m_mode != M_STOP && m_stalls < 65535) m_stalls++;
        case (m_mode)
            M_RUN: begin
                if (stall) begin
                    m_mode = M_WAIT; m_waited = 0; m_back_to_drain = 0;
                end else if (!branch_taken_EX && halt_ID) begin
                    m_mode = M_DRAIN; m_drain_left = 3;
                end
            end
            M_WAIT: begin
                if (mem_ready) begin
                    if (m_back_to_drain) begin
                        m_mode = M_DRAIN;
                        m_drain_left = (m_drain_left > 0) ? m_drain_left - 1 : 0;
                    end else m_mode = M_RUN;
                end else begin
                    m_waited = (m_waited < 255) ? m_waited + 1 : 255;
                    if (m_waited == T_MEM) m_timeout = 1;
                end
            end
            M_DRAIN: begin
                if (stall) begin
                    m_mode = M_WAIT; m_waited = 0; m_back_to_drain = 1;
                end else if (m_drain_left <= 1) m_mode = M_STOP;
                else m_drain_left--;
            end
            default: ;
        endcase
    endtask

    function automatic logic [8:0] dut_outs();
        return {halted, mem_timeout, if_id_flush, id_ex_flush,
                pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
    endfunction

    // One clock cycle: apply inputs after the falling edge, check, advance model.
    task automatic cyc(input bit mr, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input bit br, input bit hl,
                       input bit mq, input bit my);
        logic [6:0] act;
        @(negedge clk);
        mem_read_EX = mr; reg_dest_EX = rd; reg_rs_ID = rs; reg_rt_ID = rt;
        branch_taken_EX = br; halt_ID = hl; mem_req_MEM = mq; mem_ready = my;
        #2;
        act = model_action();
        check_eq("outputs", 32'(dut_outs()),
                 32'({m_mode == M_STOP, m_timeout, act}));
        check_eq("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        model_step(act);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mem_read_EX = 0; reg_dest_EX = 0; reg_rs_ID = 0; reg_rt_ID = 0;
        branch_taken_EX = 0; halt_ID = 0; mem_req_MEM = 0; mem_ready = 0;
        rst = 1'b1;
        #2;
        model_reset();
        check_eq("reset_outputs", 32'(dut_outs()), 32'(0));
        check_eq("reset_stall_cycles", 32'(stall_cycles), 32'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int stop_run;
        model_reset();
        do_reset();

        // Load r5 in EX with rs=5: one bubble cycle.
        cyc(1, 5'd5, 5'd5, 5'd2, 0, 0, 0, 0);
        check_eq("lu_pc_en", 32'(pc_en), 32'(0));
        check_eq("lu_if_id_en", 32'(if_id_en), 32'(0));
        check_eq("lu_id_ex_flush", 32'(id_ex_flush), 32'(1));
        idle();
        check_eq("lu_stall_cycles", 32'(stall_cycles), 32'(1));

        // r0 never creates a hazard.
        cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_eq("r0_pc_en", 32'(pc_en), 32'(1));

        // Branch beats load-use.
        cyc(1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0);
        check_eq("br_lu_flushes", 32'({if_id_flush, id_ex_flush, pc_en}), 32'(3'b111));

        // Memory stall of 4 cycles then release.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            check_eq("mw_enables_low", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(0));
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        check_eq("mw_release", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(5'h1f));
        idle();
        check_eq("mw_stall_cycles", 32'(stall_cycles), 32'(4));

        // Timeout after 3 wait cycles, sticky; reset mid-wait.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            check_eq("to_not_yet", 32'(mem_timeout), 32'(0));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            check_eq("to_sticky", 32'(mem_timeout), 32'(1));
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        check_eq("to_after_release", 32'(mem_timeout), 32'(1));
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        do_reset();
        cyc(1, 5'd9, 5'd3, 5'd9, 0, 0, 0, 0);
        check_eq("post_wait_reset_lu", 32'({pc_en, id_ex_flush}), 32'(2'b01));

        // Halt, one stall during drain: halted exactly 5 cycles after halt.
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) cyc(0, 0, 0, 0, 0, 0, 1, 0);
            else if (k == 3) cyc(0, 0, 0, 0, 0, 0, 1, 1);
            else idle();
            check_eq($sformatf("halt_k%0d", k), 32'(halted), 32'(k == 5));
        end
        cyc(1, 5'd4, 5'd4, 5'd4, 1, 1, 1, 0);
        check_eq("halted_ignores_inputs", 32'(dut_outs()), 32'(9'b1_0000_0000));
        do_reset();
        check_eq("halt_cleared", 32'(halted), 32'(0));

        // Reset mid-drain, then normal running.
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        do_reset();
        idle();
        check_eq("post_drain_reset_pc_en", 32'(pc_en), 32'(1));

        // Randomized traffic.
        stop_run = 0;
        for (int i = 0; i < 2000; i++) begin
            if (stop_run > 3 || $urandom_range(0, 199) == 0) begin
                do_reset();
                stop_run = 0;
            end
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
            if (m_mode == M_STOP) stop_run++;
            else stop_run = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
